// File: rtl/router_pkg.sv
// Shared types and widths for the router output-channel arbiter.
package router_pkg;

    localparam int unsigned ARB_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/router_out_arbiter_if.sv
// Handshake bundle between N_IN requesters, the arbiter and the shared output channel.
// grant_cnt_o exists only when ARB_GRANT_CNT_EN is defined.
interface router_out_arbiter_if #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned WIDTH = 6
);
    import router_pkg::*;

    logic [N_IN-1:0]            req_i;
    logic [N_IN-1:0]            ack_i;
    logic [N_IN-1:0][WIDTH-1:0] data_i;
    logic                       req_o;
    logic [WIDTH-1:0]           data_o;
    logic                       ack_o;
    logic [N_IN-1:0]            grant_o;
    logic                       busy_o;
`ifdef ARB_GRANT_CNT_EN
    logic [N_IN-1:0][ARB_CNT_W-1:0] grant_cnt_o;

    modport master (
        input  req_i, data_i, ack_o,
        output ack_i, req_o, data_o, grant_o, busy_o, grant_cnt_o
    );
    modport slave (
        output req_i, data_i, ack_o,
        input  ack_i, req_o, data_o, grant_o, busy_o, grant_cnt_o
    );
`else
    modport master (
        input  req_i, data_i, ack_o,
        output ack_i, req_o, data_o, grant_o, busy_o
    );
    modport slave (
        output req_i, data_i, ack_o,
        input  ack_i, req_o, data_o, grant_o, busy_o
    );
`endif

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_IN-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_IN-1:0]  winner,
    output logic             valid
);

    always_comb begin
        int unsigned idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            idx = (32'(ptr) + i) % N_IN;
            if (!valid && req[PTR_W'(idx)]) begin
                winner[PTR_W'(idx)] = 1'b1;
                valid               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_out_arbiter.sv
// Round-robin arbiter granting one 4-phase packet at a time onto a shared output channel.
// Optional per-requester saturating grant counters under ARB_GRANT_CNT_EN.
module router_out_arbiter
    import router_pkg::*;
#(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    router_out_arbiter_if.master bus
);

    localparam int unsigned PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    arb_state_t       state_q;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] win_q;
    logic [N_IN-1:0]  grant_q;
    logic [N_IN-1:0]  ack_q;
    logic             req_q;
    logic             busy_q;
    logic [WIDTH-1:0] data_q;

    logic [N_IN-1:0]  winner_c;
    logic             valid_c;
    logic [PTR_W-1:0] win_idx_c;
    logic [PTR_W-1:0] ptr_next_c;

    rr_pick #(
        .N_IN  (N_IN),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (bus.req_i),
        .ptr    (ptr_q),
        .winner (winner_c),
        .valid  (valid_c)
    );

    // One-hot winner to index, and the pointer slot just past the current owner.
    always_comb begin
        win_idx_c = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (winner_c[i]) begin
                win_idx_c = PTR_W'(i);
            end
        end
        ptr_next_c = (win_q == PTR_W'(N_IN - 1)) ? '0 : win_q + PTR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_c) begin
                        state_q <= SEND;
                        win_q   <= win_idx_c;
                        grant_q <= winner_c;
                        data_q  <= bus.data_i[win_idx_c];
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                SEND: begin
                    if (bus.ack_o) begin
                        state_q <= HOLD;
                        req_q   <= 1'b0;
                        ack_q   <= grant_q;
                    end
                end
                HOLD: begin
                    // Release only after both sides have returned to zero.
                    if (!bus.ack_o && !bus.req_i[win_q]) begin
                        state_q <= IDLE;
                        ack_q   <= '0;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_next_c;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= '0;
                    grant_q <= '0;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_o   = req_q;
    assign bus.ack_i   = ack_q;
    assign bus.grant_o = grant_q;
    assign bus.busy_o  = busy_q;
    assign bus.data_o  = data_q;

`ifdef ARB_GRANT_CNT_EN
    logic [N_IN-1:0][ARB_CNT_W-1:0] cnt_q;

    // Count accepted packets per requester, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == SEND && bus.ack_o) begin
            for (int unsigned k = 0; k < N_IN; k++) begin
                if (grant_q[k] && cnt_q[k] != {ARB_CNT_W{1'b1}}) begin
                    cnt_q[k] <= cnt_q[k] + ARB_CNT_W'(1);
                end
            end
        end
    end

    assign bus.grant_cnt_o = cnt_q;
`endif

endmodule

// File: doc/router_out_arbiter.md
ROUTER_OUT_ARBITER -- requirements
Module: router_out_arbiter

Interface
REQ-001 Parameter N_IN, default 4, number of requesters sharing one router output channel (proc, port1, port2, port3).
REQ-002 Parameter WIDTH, default 6, packet width in bits (X_BITS + Y_BITS + PAYLOAD).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_i[N_IN]  input  1 each  requester k presents a packet (4-phase).
REQ-006 ack_i[N_IN]  output  1 each  packet from requester k accepted downstream.
REQ-007 data_i[N_IN]  input  WIDTH each  packet of requester k, stable while req_i[k]=1.
REQ-008 req_o  output  1  request toward the shared output channel.
REQ-009 data_o  output  WIDTH  registered packet of the granted requester.
REQ-010 ack_o  input  1  acknowledge from the shared output channel.
REQ-011 grant_o  output  N_IN  one-hot current owner, all-zero when idle.
REQ-012 busy_o  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states IDLE, SEND, HOLD; one packet per ownership.
REQ-014 IDLE: if any req_i[k]=1, pick winner by round-robin starting at pointer ptr, capture data_i[winner] into data_o, set grant_o, go SEND next cycle.
REQ-015 Latency: req_o rises exactly 1 cycle after the edge at which req_i[k]=1 is sampled in IDLE.
REQ-016 SEND: req_o=1, data_o held constant; on sampled ack_o=1 go HOLD, req_o=0, ack_i[winner]=1.
REQ-017 HOLD: ack_i[winner]=1 until both ack_o=0 and req_i[winner]=0 are sampled; then ack_i=0, grant_o=0, ptr=(winner+1) mod N_IN, go IDLE.
REQ-018 Simultaneous requests: lowest index at or after ptr wins, wrapping past N_IN-1 to 0.
REQ-019 Non-winning requesters get ack_i=0 and stay pending; no request is ever granted twice without a full return-to-zero.
REQ-020 req_i dropped in IDLE before sampling: not granted; req_i of others changing during SEND/HOLD: no effect.
REQ-021 ack_o=1 sampled in IDLE is ignored; ack_o held high entering HOLD delays IDLE until it falls.
REQ-022 At most one ack_i bit high at any time; req_o and any ack_i never high in the same cycle.

Reset
REQ-023 rst=1 forces immediately: state IDLE, ptr=0, req_o=0, ack_i all 0, grant_o=0, busy_o=0, data_o=0.
REQ-024 rst mid-SEND or mid-HOLD abandons the packet; after release, arbitration restarts from ptr=0.

Configuration
REQ-025 Macro ARB_GRANT_CNT_EN defined: output grant_cnt_o[N_IN], 8 bits each, saturating at 255, incremented on each SEND->HOLD transition for the winner, cleared by rst.
REQ-026 Macro ARB_GRANT_CNT_EN undefined: port grant_cnt_o and counters absent; all other behaviour identical.

Structure
REQ-027 router_pkg holds arb_state_t (IDLE, SEND, HOLD) and ARB_CNT_W=8.
REQ-028 Combinational round-robin selection lives in sub-module rr_pick (inputs req vector, ptr; outputs one-hot winner, valid); FSM and registers stay in router_out_arbiter.

Verification
REQ-029 Single request: req_i[2]=1, data_i[2]=6'h2A -> next cycle req_o=1, data_o=6'h2A, grant_o=4'b0100; ack_o=1 -> ack_i[2]=1; drop req_i[2], ack_o -> ack_i[2]=0, ptr=3.
REQ-030 All four request from reset -> grant order 0,1,2,3, then 0 again when requester 0 re-requests.
REQ-031 ack_o held high 5 cycles after req_i[1] falls -> ack_i[1] stays 1 until ack_o=0, then IDLE.
REQ-032 rst pulse during SEND for requester 3 -> req_o, ack_i, grant_o=0 same cycle; next grant after release goes to lowest pending index from 0.
REQ-033 With ARB_GRANT_CNT_EN: 300 grants to requester 1 -> grant_cnt_o[1]=255, others 0; without macro the same stimulus passes REQ-029..032 unchanged.
